// File: rtl/scene_key_encoder_pkg.sv
// Shared scene codes, logical button indices and the key-to-button map
// used by the scene key encoder.
package scene_key_encoder_pkg;

  localparam int unsigned KEY_COUNT   = 4;
  localparam int unsigned KEY_W       = $clog2(KEY_COUNT);
  localparam int unsigned NUM_BUTTONS = 10;
  localparam int unsigned SCENE_W     = 7;

  localparam logic [SCENE_W-1:0] SCENE_START    = 7'b0000001;
  localparam logic [SCENE_W-1:0] SCENE_CUSTOM1  = 7'b0000010;
  localparam logic [SCENE_W-1:0] SCENE_CUSTOM2  = 7'b0000100;
  localparam logic [SCENE_W-1:0] SCENE_CUSTOM3  = 7'b0001000;
  localparam logic [SCENE_W-1:0] SCENE_PAUSE    = 7'b0010000;
  localparam logic [SCENE_W-1:0] SCENE_GAMEOVER = 7'b0100000;
  localparam logic [SCENE_W-1:0] SCENE_METHOD   = 7'b1000000;
  localparam logic [SCENE_W-1:0] SCENE_WIN      = 7'b1111111;

  typedef enum logic [3:0] {
    BTN_START         = 4'd0,
    BTN_PAUSE         = 4'd1,
    BTN_CONTINUE      = 4'd2,
    BTN_RESTART       = 4'd3,
    BTN_METHOD        = 4'd4,
    BTN_CANCLE        = 4'd5,
    BTN_FIRST_CUSTOM  = 4'd6,
    BTN_SECOND_CUSTOM = 4'd7,
    BTN_THIRD_CUSTOM  = 4'd8,
    BTN_EXIT_GAME     = 4'd9
  } button_e;

  typedef struct packed {
    logic    valid;
    button_e btn;
  } button_sel_t;

  function automatic button_sel_t pick(input button_e b);
    button_sel_t s;
    s.valid = 1'b1;
    s.btn   = b;
    return s;
  endfunction

  // Logical button for one physical key in the given scene; valid=0 means the press is dropped.
  function automatic button_sel_t map_key(input logic [SCENE_W-1:0] scene,
                                          input logic [KEY_W-1:0]   key);
    button_sel_t s;
    s.valid = 1'b0;
    s.btn   = BTN_START;
    case (scene)
      SCENE_START: begin
        case (key)
          2'd0:    s = pick(BTN_START);
          2'd1:    s = pick(BTN_METHOD);
          2'd2:    s = pick(BTN_SECOND_CUSTOM);
          default: s = pick(BTN_THIRD_CUSTOM);
        endcase
      end
      SCENE_CUSTOM1, SCENE_CUSTOM2, SCENE_CUSTOM3: begin
        case (key)
          2'd0:    s = pick(BTN_PAUSE);
          2'd1:    s = pick(BTN_RESTART);
          2'd3:    s = pick(BTN_EXIT_GAME);
          default: ;
        endcase
      end
      SCENE_PAUSE: begin
        case (key)
          2'd0:    s = pick(BTN_CONTINUE);
          2'd1:    s = pick(BTN_METHOD);
          2'd2:    s = pick(BTN_RESTART);
          default: s = pick(BTN_EXIT_GAME);
        endcase
      end
      SCENE_METHOD: begin
        case (key)
          2'd0:    s = pick(BTN_CANCLE);
          2'd1:    s = pick(BTN_RESTART);
          2'd3:    s = pick(BTN_EXIT_GAME);
          default: ;
        endcase
      end
      SCENE_GAMEOVER, SCENE_WIN: begin
        case (key)
          2'd1:    s = pick(BTN_RESTART);
          2'd3:    s = pick(BTN_EXIT_GAME);
          default: ;
        endcase
      end
      default: ;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/scene_key_encoder_key_debounce.sv
// One physical key: 2-FF synchronizer, stability-count debounce and a
// registered one-cycle pulse on each accepted release->press transition.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic key_press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             level_q;
  logic [CNT_W-1:0] cnt_q;
  logic             press_q;

  // Counter runs only while the synced level disagrees with the accepted level,
  // so any bounce back to the accepted level restarts the stability window.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 2'b00;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_raw};
      press_q <= 1'b0;
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        level_q <= sync_q[1];
        press_q <= sync_q[1];
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign key_press = press_q;

endmodule

// File: rtl/scene_key_encoder.sv
// Board keys to scene-dependent logical button pulses: four debounced keys,
// scene-based mapping and a fixed-length pulse generator.
module scene_key_encoder
  import scene_key_encoder_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned PULSE_LEN       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [KEY_COUNT-1:0] key_raw,
  input  logic [SCENE_W-1:0]   state_number,
  output logic                 start_button,
  output logic                 pause_button,
  output logic                 continue_button,
  output logic                 restart_button,
  output logic                 method_button,
  output logic                 cancle_button,
  output logic                 first_custom_button,
  output logic                 second_custom_button,
  output logic                 third_custom_button,
  output logic                 exit_game_button,
  output logic                 key_busy
);

  localparam int unsigned LEN_W = (PULSE_LEN > 2) ? $clog2(PULSE_LEN) : 1;
  localparam logic [LEN_W-1:0] LEN_LAST = LEN_W'(PULSE_LEN - 1);

  typedef enum logic {
    ST_IDLE,
    ST_PULSE
  } state_e;

  state_e                 state_q, state_d;
  button_e                sel_q, sel_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [NUM_BUTTONS-1:0] button_q, button_d;
  logic                   busy_q, busy_d;

  logic [KEY_COUNT-1:0]   press;
  logic                   press_any;
  logic [KEY_W-1:0]       press_idx;
  button_sel_t            hit;

  for (genvar k = 0; k < KEY_COUNT; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
      .clk      (clk),
      .rst      (rst),
      .key_raw  (key_raw[k]),
      .key_press(press[k])
    );
  end

  // Lowest-index press wins; its mapping is taken from the scene in that same cycle.
  always_comb begin
    press_any = 1'b0;
    press_idx = '0;
    for (int unsigned i = 0; i < KEY_COUNT; i++) begin
      if (press[i] && !press_any) begin
        press_any = 1'b1;
        press_idx = KEY_W'(i);
      end
    end
    hit = map_key(state_number, press_idx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sel_q    <= BTN_START;
      len_q    <= '0;
      button_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      len_q    <= len_d;
      button_q <= button_d;
      busy_q   <= busy_d;
    end
  end

  // Presses seen while pulsing are ignored; the button is frozen at acceptance.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    len_d    = len_q;
    button_d = '0;
    busy_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (press_any && hit.valid) begin
          state_d = ST_PULSE;
          sel_d   = hit.btn;
          len_d   = '0;
        end
      end
      ST_PULSE: begin
        if (len_q == LEN_LAST) begin
          state_d = ST_IDLE;
        end else begin
          len_d = len_q + LEN_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_PULSE) begin
      button_d[sel_d] = 1'b1;
      busy_d          = 1'b1;
    end
  end

  assign start_button         = button_q[BTN_START];
  assign pause_button         = button_q[BTN_PAUSE];
  assign continue_button      = button_q[BTN_CONTINUE];
  assign restart_button       = button_q[BTN_RESTART];
  assign method_button        = button_q[BTN_METHOD];
  assign cancle_button        = button_q[BTN_CANCLE];
  assign first_custom_button  = button_q[BTN_FIRST_CUSTOM];
  assign second_custom_button = button_q[BTN_SECOND_CUSTOM];
  assign third_custom_button  = button_q[BTN_THIRD_CUSTOM];
  assign exit_game_button     = button_q[BTN_EXIT_GAME];
  assign key_busy             = busy_q;

endmodule
